spike_tick_scheduler: RTL

- Sequences one time-step (tick) of the spike-input path.
- Per tick: presents the tick value, starts the spike filter, waits for it to finish, drains the matched neuron addresses from the event FIFO to the neuron core, holds for a programmed tick period, then advances.
- Sits between the bus-mapped configuration registers and the spike filter / event FIFO / neuron core.

---
 rtl/spike_pkg.sv | 22 ++
 rtl/tick_period_timer.sv | 46 ++++
 rtl/spike_tick_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spike_pkg.sv
// Shared types and helpers for the spike-input tick scheduler.
package spike_pkg;

    localparam int unsigned TICK_W_DEF = 8;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StFilter,
        StDrainRd,
        StDrainCap,
        StDrainHs,
        StWaitPeriod,
        StAdvance,
        StDone
    } sched_state_e;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_period_timer.sv
// Per-tick cycle counter with latched period, expiry decode and sticky overrun flag.
module tick_period_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_check,
    input  logic                i_clear,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_expired,
    output logic                o_overrun
);

    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_overrun;
    logic [PERIOD_W:0]   w_adv_len;

    // r_cnt counts cycles completed since START, so an ADVANCE entered next
    // would be cycle r_cnt+2 of the tick (START being cycle 1).
    assign w_adv_len = {1'b0, r_cnt} + (PERIOD_W + 1)'(2);
    assign o_expired = (w_adv_len >= {1'b0, r_period});
    assign o_overrun = r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_period  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_start) begin
                r_cnt    <= PERIOD_W'(1);
                r_period <= i_period;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end
            if (i_clear) begin
                r_overrun <= 1'b0;
            end else if (i_check && (w_adv_len > {1'b0, r_period})) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_tick_scheduler.sv
// Tick sequencer: start filter, drain matched events to the neuron core, pace ticks.
module spike_tick_scheduler
    import spike_pkg::*;
#(
    parameter int unsigned N        = 256,
    parameter int unsigned TICK_W   = TICK_W_DEF,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable_i,
    input  logic [PERIOD_W-1:0]           period_i,
    input  logic [TICK_W-1:0]             num_ticks_i,
    output logic [TICK_W-1:0]             tick_o,
    output logic                          next_tick_o,
    output logic                          filter_start_o,
    input  logic                          filter_done_i,
    input  logic                          FIFO_empty_i,
    output logic                          FIFO_r_en_o,
    input  logic [addr_width(N)-1:0]      FIFO_r_data_i,
    output logic                          event_valid_o,
    output logic [addr_width(N)-1:0]      event_addr_o,
    input  logic                          event_ready_i,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          run_done_o
);

    localparam int unsigned AW = addr_width(N);

    sched_state_e      r_state;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W:0]   r_remain;
    logic              r_next_tick;
    logic              r_filter_start;
    logic              r_event_valid;
    logic [AW-1:0]     r_event_addr;
    logic              r_busy;
    logic              r_run_done;
    logic              w_expired;
    logic              w_check;
    logic              w_clear;

    assign w_check = (r_state == StDrainRd) && FIFO_empty_i;
    assign w_clear = (r_state == StIdle) && enable_i;

    tick_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_start   (r_state == StStart),
        .i_check   (w_check),
        .i_clear   (w_clear),
        .i_period  (period_i),
        .o_expired (w_expired),
        .o_overrun (overrun_o)
    );

    assign tick_o         = r_tick;
    assign next_tick_o    = r_next_tick;
    assign filter_start_o = r_filter_start;
    assign event_valid_o  = r_event_valid;
    assign event_addr_o   = r_event_addr;
    assign busy_o         = r_busy;
    assign run_done_o     = r_run_done;
    // Pop must land in the same cycle the empty flag is seen, so it stays combinational.
    assign FIFO_r_en_o    = (r_state == StDrainRd) && !FIFO_empty_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= StIdle;
            r_tick         <= '0;
            r_remain       <= '0;
            r_next_tick    <= 1'b0;
            r_filter_start <= 1'b0;
            r_event_valid  <= 1'b0;
            r_event_addr   <= '0;
            r_busy         <= 1'b0;
            r_run_done     <= 1'b0;
        end else begin
            r_next_tick    <= 1'b0;
            r_filter_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (enable_i) begin
                        r_state        <= StStart;
                        r_filter_start <= 1'b1;
                        r_busy         <= 1'b1;
                        r_tick         <= '0;
                        // Zero requests a full 2^TICK_W run.
                        r_remain       <= (num_ticks_i == '0) ? {1'b1, {TICK_W{1'b0}}}
                                                              : {1'b0, num_ticks_i};
                    end
                end
                StStart: r_state <= StFilter;
                StFilter: begin
                    if (filter_done_i) r_state <= StDrainRd;
                end
                StDrainRd: begin
                    if (!FIFO_empty_i) begin
                        r_state <= StDrainCap;
                    end else if (w_expired) begin
                        r_state     <= StAdvance;
                        r_next_tick <= 1'b1;
                    end else begin
                        r_state <= StWaitPeriod;
                    end
                end
                StDrainCap: begin
                    r_event_addr  <= FIFO_r_data_i;
                    r_event_valid <= 1'b1;
                    r_state       <= StDrainHs;
                end
                StDrainHs: begin
                    if (event_ready_i) begin
                        r_event_valid <= 1'b0;
                        r_state       <= StDrainRd;
                    end
                end
                StWaitPeriod: begin
                    if (w_expired) begin
                        r_state     <= StAdvance;
                        r_next_tick <= 1'b1;
                    end
                end
                StAdvance: begin
                    r_remain <= r_remain - (TICK_W + 1)'(1);
                    if (r_remain == (TICK_W + 1)'(1)) begin
                        r_state    <= StDone;
                        r_busy     <= 1'b0;
                        r_run_done <= 1'b1;
                    end else if (!enable_i) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tick         <= r_tick + TICK_W'(1);
                        r_state        <= StStart;
                        r_filter_start <= 1'b1;
                    end
                end
                StDone: begin
                    if (!enable_i) begin
                        r_state    <= StIdle;
                        r_run_done <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
